ddr3_burst_sched: RTL and testbench
===================================

Name: ddr3_burst_sched

Overview:
- Sequences the MIG 7-series user (app_*) interface for the frame-buffer path.
- Drains the write FIFO into DDR3 and fills the read FIFO from DDR3 in fixed-length bursts.
- Arbitrates write and read requests round-robin and manages ping-pong frame banks, with frame restarts driven by the source and display load pulses.
- Sits between ddr3_fifo_ctrl and mig_7series_0, inside the DDR3 top level.

Parameters:
- ADDR_W, 28, width of app_addr and of the address window inputs.
- CNT_W, 11, width of the FIFO level inputs.
- ADDR_STEP, 8, app_addr increment per 256-bit beat (BL8 on x32 DDR3).
- BANK_OFFSET, 28'h0200000, address offset added when ping-pong bank 1 is selected.
- RD_THRESH, 512, a read burst is allowed only while rfifo_wcount < RD_THRESH.

Ports:
- ui_clk  in  1  MIG user clock; sole clock of the block.
- rst_n  in  1  asynchronous reset, active-low.
- init_calib_complete  in  1  MIG calibration done.
- app_rdy  in  1  MIG command ready.
- app_wdf_rdy  in  1  MIG write-data ready.
- app_rd_data_valid  in  1  MIG read data valid.
- app_addr  out  ADDR_W  command address.
- app_cmd  out  3  3'b000 = write, 3'b001 = read.
- app_en  out  1  command strobe.
- app_wdf_wren  out  1  write-data strobe; also the write FIFO read enable.
- app_wdf_end  out  1  last beat of write data; equals app_wdf_wren.
- wr_addr_min / wr_addr_max  in  ADDR_W  write window; max is exclusive.
- rd_addr_min / rd_addr_max  in  ADDR_W  read window; max is exclusive.
- wr_burst_len / rd_burst_len  in  8  beats per burst, 1..255; 0 is treated as 1.
- wfifo_rcount  in  CNT_W  words available in the write FIFO.
- rfifo_wcount  in  CNT_W  words held in the read FIFO.
- wr_load / rd_load  in  1  frame restart pulses from foreign clock domains.
- rd_enable  in  1  reads permitted.
- pingpang_en  in  1  enables bank swapping.
- rfifo_wren  out  1  read FIFO write enable; equals app_rd_data_valid.
- wr_bank / rd_bank  out  1  current bank of each stream.

Behaviour:
- Reset state: all outputs 0, app_cmd = 3'b001, FSM in WAIT_CAL, both address counters at their min, both banks 0, last-grant = read.
- wr_load and rd_load each pass through a 2-FF synchronizer followed by a rising-edge detector.
- A detected load sets a pending flag for its stream.
- The pending flag is applied only in ARB: the address counter returns to min, the bank is unchanged, then the flag clears.
- FSM states:
  - WAIT_CAL -> ARB when init_calib_complete = 1.
  - ARB: wreq = wfifo_rcount >= wr_burst_len; rreq = rd_enable && rfifo_wcount < RD_THRESH.
    - Both requesting: grant the stream not granted last.
    - One requesting: grant it.
    - Grant decision takes 1 cycle, then -> WRITE or READ with beat counter = 0.
  - WRITE:
    - app_en = app_wdf_wren = app_wdf_end = 1; app_addr = wr_addr + (wr_bank ? BANK_OFFSET : 0).
    - A beat completes only in a cycle where app_rdy && app_wdf_rdy. Otherwise the outputs hold and nothing advances.
    - After wr_burst_len beats -> ARB.
  - READ:
    - app_en = 1, app_cmd = 3'b001, app_addr = rd_addr + (rd_bank ? BANK_OFFSET : 0).
    - A beat completes when app_rdy. After rd_burst_len beats -> ARB.
    - Read data returns asynchronously to the FSM via rfifo_wren.
- Address counters:
  - Each completed beat adds ADDR_STEP.
  - If the next address >= max, the counter wraps to min.
  - On a write wrap with pingpang_en = 1, wr_bank toggles and rd_bank is set to the old wr_bank, so reads always target the last completed frame.
  - With pingpang_en = 0, both banks are forced to 0.
- Simultaneous events:
  - A load detected during a burst is deferred to the next ARB; the burst is never truncated.
  - A wrap on the same beat as a pending load: the wrap (bank toggle) is applied, then the load resets the address.
- init_calib_complete falling:
  - Next cycle all strobes drop and the FSM goes to WAIT_CAL.
  - Counters, banks and pending flags are held; the interrupted burst is not resumed.
- rst_n low mid-burst: immediate asynchronous return to the reset state.

Optional Feature:
- Macro: DDR3_RD_PRIORITY_EN.
- Defined: in ARB, rreq always wins over wreq. This protects HDMI readout from underflow, and last-grant is ignored.
- Undefined: round-robin arbitration as described in Behaviour.

Test Plan:
- Reset then calibration: init_calib_complete rises at cycle 20 -> no app_en before cycle 21; first grant when wfifo_rcount = 64 with wr_burst_len = 64 -> 64 write beats at addresses 0, 8, ... 504.
- Backpressure: app_wdf_rdy held low for 5 cycles mid-burst -> app_addr and the beat count freeze; total app_wdf_wren-accepted beats = wr_burst_len exactly.
- Ping-pong: wr window 0..1024, pingpang_en = 1, burst 64 -> after 2 bursts wr_bank = 1, rd_bank = 0, and the next write address is 0x0200000.
- Arbitration: wreq and rreq held high continuously -> grants alternate W, R, W, R; with DDR3_RD_PRIORITY_EN defined -> R only while rreq holds.
- Deferred load: rd_load pulse during a read burst -> the burst completes at full length, and the next read starts at rd_addr_min.
- Calibration loss: init_calib_complete drops mid-write -> app_en = 0 next cycle and the FSM sits in WAIT_CAL; on recovery, writes resume at the held address.

Source files
------------

// File: rtl/ddr3_burst_sched_if.sv
// MIG 7-series app_* user-interface bundle between the burst scheduler (master)
// and the memory controller (slave).
interface ddr3_burst_sched_if #(
  parameter int ADDR_W = 28
) ();
  logic              init_calib_complete;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic              app_rd_data_valid;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_wdf_wren;
  logic              app_wdf_end;

  modport master (
    input  init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid,
    output app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_end
  );

  modport slave (
    output init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid,
    input  app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/ddr3_burst_sched.sv
// Frame-buffer DDR3 burst scheduler: round-robin write/read bursts on the MIG app_* port
// with ping-pong frame banks. Define DDR3_RD_PRIORITY_EN to make reads always win arbitration.
module ddr3_burst_sched #(
  parameter int                ADDR_W      = 28,
  parameter int                CNT_W       = 11,
  parameter int                ADDR_STEP   = 8,
  parameter logic [ADDR_W-1:0] BANK_OFFSET = ADDR_W'(28'h0200000),
  parameter int                RD_THRESH   = 512
) (
  input  logic                ui_clk,
  input  logic                rst_n,
  ddr3_burst_sched_if.master  app,
  input  logic [ADDR_W-1:0]   wr_addr_min,
  input  logic [ADDR_W-1:0]   wr_addr_max,
  input  logic [ADDR_W-1:0]   rd_addr_min,
  input  logic [ADDR_W-1:0]   rd_addr_max,
  input  logic [7:0]          wr_burst_len,
  input  logic [7:0]          rd_burst_len,
  input  logic [CNT_W-1:0]    wfifo_rcount,
  input  logic [CNT_W-1:0]    rfifo_wcount,
  input  logic                wr_load,
  input  logic                rd_load,
  input  logic                rd_enable,
  input  logic                pingpang_en,
  output logic                rfifo_wren,
  output logic                wr_bank,
  output logic                rd_bank
);

  typedef enum logic [1:0] {
    WAIT_CAL = 2'd0,
    ARB      = 2'd1,
    WRITE    = 2'd2,
    READ     = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [7:0]        beat_r, beat_nxt_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_nxt_s, rd_addr_r, rd_addr_nxt_s;
  logic              wr_bank_r, wr_bank_nxt_s, rd_bank_r, rd_bank_nxt_s;
  logic              last_wr_r, last_wr_nxt_s;
  logic              wr_pend_r, wr_pend_nxt_s, rd_pend_r, rd_pend_nxt_s;
  logic [2:0]        wr_load_sync_r, rd_load_sync_r;
  logic              wr_load_det_s, rd_load_det_s;
  logic [7:0]        wr_len_s, rd_len_s;
  logic              wreq_s, rreq_s, grant_wr_s, grant_rd_s;
  logic              wr_fire_s, rd_fire_s;
  logic [ADDR_W-1:0] wr_step_s, rd_step_s;
  logic              wr_wrap_s, rd_wrap_s;
  logic [ADDR_W-1:0] app_addr_nxt_s, app_addr_r;
  logic [2:0]        app_cmd_nxt_s, app_cmd_r;
  logic              app_en_nxt_s, app_en_r, app_wdf_wren_nxt_s, app_wdf_wren_r;

  assign wr_len_s      = (wr_burst_len == 8'd0) ? 8'd1 : wr_burst_len;
  assign rd_len_s      = (rd_burst_len == 8'd0) ? 8'd1 : rd_burst_len;
  assign wr_load_det_s = wr_load_sync_r[1] & ~wr_load_sync_r[2];
  assign rd_load_det_s = rd_load_sync_r[1] & ~rd_load_sync_r[2];
  assign wreq_s        = (wfifo_rcount >= CNT_W'(wr_len_s));
  assign rreq_s        = rd_enable && (rfifo_wcount < CNT_W'(RD_THRESH));
`ifdef DDR3_RD_PRIORITY_EN
  assign grant_rd_s    = rreq_s;
  assign grant_wr_s    = wreq_s && !rreq_s;
`else
  assign grant_rd_s    = rreq_s && (!wreq_s || last_wr_r);
  assign grant_wr_s    = wreq_s && (!rreq_s || !last_wr_r);
`endif
  assign wr_fire_s     = (state_r == WRITE) && app.init_calib_complete && app.app_rdy && app.app_wdf_rdy;
  assign rd_fire_s     = (state_r == READ) && app.init_calib_complete && app.app_rdy;
  assign wr_step_s     = wr_addr_r + ADDR_W'(ADDR_STEP);
  assign rd_step_s     = rd_addr_r + ADDR_W'(ADDR_STEP);
  assign wr_wrap_s     = (wr_step_s >= wr_addr_max);
  assign rd_wrap_s     = (rd_step_s >= rd_addr_max);

  // Next-state, counter, bank and pending-load logic
  always_comb begin
    state_nxt_s   = state_r;
    beat_nxt_s    = beat_r;
    wr_addr_nxt_s = wr_addr_r;
    rd_addr_nxt_s = rd_addr_r;
    wr_bank_nxt_s = wr_bank_r;
    rd_bank_nxt_s = rd_bank_r;
    last_wr_nxt_s = last_wr_r;
    wr_pend_nxt_s = wr_pend_r | wr_load_det_s;
    rd_pend_nxt_s = rd_pend_r | rd_load_det_s;
    case (state_r)
      WAIT_CAL: begin
        if (app.init_calib_complete) state_nxt_s = ARB;
        else                         state_nxt_s = WAIT_CAL;
      end
      ARB: begin
        // Frame restarts land here only, so a burst is never cut short
        beat_nxt_s = 8'd0;
        if (wr_pend_r) begin
          wr_addr_nxt_s = wr_addr_min;
          wr_pend_nxt_s = wr_load_det_s;
        end else begin
          wr_addr_nxt_s = wr_addr_r;
        end
        if (rd_pend_r) begin
          rd_addr_nxt_s = rd_addr_min;
          rd_pend_nxt_s = rd_load_det_s;
        end else begin
          rd_addr_nxt_s = rd_addr_r;
        end
        if (!app.init_calib_complete) begin
          state_nxt_s = WAIT_CAL;
        end else if (grant_rd_s) begin
          state_nxt_s   = READ;
          last_wr_nxt_s = 1'b0;
        end else if (grant_wr_s) begin
          state_nxt_s   = WRITE;
          last_wr_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ARB;
        end
      end
      WRITE: begin
        if (!app.init_calib_complete) begin
          state_nxt_s = WAIT_CAL;
        end else if (wr_fire_s) begin
          beat_nxt_s    = beat_r + 8'd1;
          wr_addr_nxt_s = wr_wrap_s ? wr_addr_min : wr_step_s;
          if (wr_wrap_s) begin
            wr_bank_nxt_s = ~wr_bank_r;
            rd_bank_nxt_s = wr_bank_r;
          end else begin
            wr_bank_nxt_s = wr_bank_r;
          end
          if (beat_r == (wr_len_s - 8'd1)) state_nxt_s = ARB;
          else                              state_nxt_s = WRITE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      READ: begin
        if (!app.init_calib_complete) begin
          state_nxt_s = WAIT_CAL;
        end else if (rd_fire_s) begin
          beat_nxt_s    = beat_r + 8'd1;
          rd_addr_nxt_s = rd_wrap_s ? rd_addr_min : rd_step_s;
          if (beat_r == (rd_len_s - 8'd1)) state_nxt_s = ARB;
          else                              state_nxt_s = READ;
        end else begin
          state_nxt_s = READ;
        end
      end
      default: begin
        state_nxt_s = WAIT_CAL;
      end
    endcase
    if (!pingpang_en) begin
      wr_bank_nxt_s = 1'b0;
      rd_bank_nxt_s = 1'b0;
    end else begin
      wr_bank_nxt_s = wr_bank_nxt_s;
    end
  end

  // Outputs are registered from the next state so they line up with the beat being presented
  always_comb begin
    app_en_nxt_s       = (state_nxt_s == WRITE) || (state_nxt_s == READ);
    app_wdf_wren_nxt_s = (state_nxt_s == WRITE);
    app_cmd_nxt_s      = (state_nxt_s == WRITE) ? 3'b000 : 3'b001;
    if (state_nxt_s == WRITE) begin
      app_addr_nxt_s = wr_addr_nxt_s + (wr_bank_nxt_s ? BANK_OFFSET : {ADDR_W{1'b0}});
    end else if (state_nxt_s == READ) begin
      app_addr_nxt_s = rd_addr_nxt_s + (rd_bank_nxt_s ? BANK_OFFSET : {ADDR_W{1'b0}});
    end else begin
      app_addr_nxt_s = {ADDR_W{1'b0}};
    end
  end

  // Load-pulse synchronizers: [0] meta, [1] synced, [2] previous for edge detect
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_load_sync_r <= 3'b000;
      rd_load_sync_r <= 3'b000;
    end else begin
      wr_load_sync_r <= {wr_load_sync_r[1:0], wr_load};
      rd_load_sync_r <= {rd_load_sync_r[1:0], rd_load};
    end
  end

  // State, counters and output registers; pending flags start set so the first ARB loads the window minimums
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= WAIT_CAL;
      beat_r         <= 8'd0;
      wr_addr_r      <= {ADDR_W{1'b0}};
      rd_addr_r      <= {ADDR_W{1'b0}};
      wr_bank_r      <= 1'b0;
      rd_bank_r      <= 1'b0;
      last_wr_r      <= 1'b0;
      wr_pend_r      <= 1'b1;
      rd_pend_r      <= 1'b1;
      app_addr_r     <= {ADDR_W{1'b0}};
      app_cmd_r      <= 3'b001;
      app_en_r       <= 1'b0;
      app_wdf_wren_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      beat_r         <= beat_nxt_s;
      wr_addr_r      <= wr_addr_nxt_s;
      rd_addr_r      <= rd_addr_nxt_s;
      wr_bank_r      <= wr_bank_nxt_s;
      rd_bank_r      <= rd_bank_nxt_s;
      last_wr_r      <= last_wr_nxt_s;
      wr_pend_r      <= wr_pend_nxt_s;
      rd_pend_r      <= rd_pend_nxt_s;
      app_addr_r     <= app_addr_nxt_s;
      app_cmd_r      <= app_cmd_nxt_s;
      app_en_r       <= app_en_nxt_s;
      app_wdf_wren_r <= app_wdf_wren_nxt_s;
    end
  end

  assign app.app_addr     = app_addr_r;
  assign app.app_cmd      = app_cmd_r;
  assign app.app_en       = app_en_r;
  assign app.app_wdf_wren = app_wdf_wren_r;
  assign app.app_wdf_end  = app_wdf_wren_r;
  assign rfifo_wren       = app.app_rd_data_valid;
  assign wr_bank          = wr_bank_r;
  assign rd_bank          = rd_bank_r;

endmodule

// File: tb/tb_ddr3_burst_sched.sv
// Directed self-checking bench for ddr3_burst_sched: calibration, backpressure, ping-pong,
// arbitration, deferred load, calibration loss and asynchronous reset.
module tb_ddr3_burst_sched;
  localparam int ADDR_W = 28;
  localparam int CNT_W  = 11;
`ifdef DDR3_RD_PRIORITY_EN
  localparam bit RD_PRIO = 1'b1;
`else
  localparam bit RD_PRIO = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
  } beat_t;

  logic              ui_clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] wr_addr_min, wr_addr_max, rd_addr_min, rd_addr_max;
  logic [7:0]        wr_burst_len, rd_burst_len;
  logic [CNT_W-1:0]  wfifo_rcount, rfifo_wcount;
  logic              wr_load, rd_load, rd_enable, pingpang_en;
  logic              rfifo_wren, wr_bank, rd_bank;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t beats[$];
  beat_t grants[$];
  logic  en_prev  = 1'b0;
  logic [ADDR_W-1:0] held_addr;
  logic [ADDR_W-1:0] exp_base;
  logic [2:0]        exp_cmd [4];
  logic [ADDR_W-1:0] exp_addr[4];

  always #5 ui_clk = ~ui_clk;

  ddr3_burst_sched_if #(.ADDR_W(ADDR_W)) mig ();

  ddr3_burst_sched dut (
    .ui_clk       (ui_clk),
    .rst_n        (rst_n),
    .app          (mig.master),
    .wr_addr_min  (wr_addr_min),
    .wr_addr_max  (wr_addr_max),
    .rd_addr_min  (rd_addr_min),
    .rd_addr_max  (rd_addr_max),
    .wr_burst_len (wr_burst_len),
    .rd_burst_len (rd_burst_len),
    .wfifo_rcount (wfifo_rcount),
    .rfifo_wcount (rfifo_wcount),
    .wr_load      (wr_load),
    .rd_load      (rd_load),
    .rd_enable    (rd_enable),
    .pingpang_en  (pingpang_en),
    .rfifo_wren   (rfifo_wren),
    .wr_bank      (wr_bank),
    .rd_bank      (rd_bank)
  );

  // Log accepted beats and burst starts on the falling edge, away from the active edge
  always @(negedge ui_clk) begin
    if (rst_n && mig.app_en && mig.app_rdy && mig.init_calib_complete &&
        (mig.app_cmd != 3'b000 || mig.app_wdf_rdy))
      beats.push_back('{cmd: mig.app_cmd, addr: mig.app_addr});
    if (rst_n && mig.app_en && !en_prev)
      grants.push_back('{cmd: mig.app_cmd, addr: mig.app_addr});
    en_prev <= mig.app_en;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (beats.size() < n) check_eq({tag, "_timeout"}, 64'(beats.size()), 64'(n));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (mig.app_en && k < 400) begin
      tick();
      k++;
    end
    check_eq({tag, "_idle"}, 64'(mig.app_en), 64'd0);
    tick();
  endtask

  task automatic check_seq(input logic [ADDR_W-1:0] start, input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= beats.size()) bad++;
      else if (beats[i].addr !== start + ADDR_W'(i * 8)) bad++;
    end
    check_eq(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_seen;
    rst_n = 1'b0;
    mig.init_calib_complete = 1'b0;
    mig.app_rdy = 1'b1;
    mig.app_wdf_rdy = 1'b1;
    mig.app_rd_data_valid = 1'b0;
    wr_addr_min = 28'h0000000;  wr_addr_max = 28'h0000400;
    rd_addr_min = 28'h0000100;  rd_addr_max = 28'h0000400;
    wr_burst_len = 8'd64;  rd_burst_len = 8'd4;
    wfifo_rcount = 11'd64; rfifo_wcount = 11'd0;
    wr_load = 1'b0; rd_load = 1'b0; rd_enable = 1'b0; pingpang_en = 1'b1;

    repeat (3) tick();
    check_eq("rst_app_en",   64'(mig.app_en), 64'd0);
    check_eq("rst_app_cmd",  64'(mig.app_cmd), 64'd1);
    check_eq("rst_app_addr", 64'(mig.app_addr), 64'd0);
    check_eq("rst_wren",     64'(mig.app_wdf_wren), 64'd0);
    check_eq("rst_banks",    64'({wr_bank, rd_bank}), 64'd0);
    mig.app_rd_data_valid = 1'b1;
    #1 check_eq("rfifo_wren_hi", 64'(rfifo_wren), 64'd1);
    mig.app_rd_data_valid = 1'b0;
    #1 check_eq("rfifo_wren_lo", 64'(rfifo_wren), 64'd0);

    // Calibration arrives at cycle 20; no strobe may appear before that
    rst_n = 1'b1;
    en_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mig.app_en) en_seen++;
    end
    check_eq("precal_no_en", 64'(en_seen), 64'd0);
    mig.init_calib_complete = 1'b1;
    tick();
    check_eq("cal_arb_cycle_en", 64'(mig.app_en), 64'd0);
    tick();
    check_eq("first_wr_en",   64'(mig.app_en), 64'd1);
    check_eq("first_wr_cmd",  64'(mig.app_cmd), 64'd0);
    check_eq("first_wr_end",  64'(mig.app_wdf_end), 64'd1);
    wait_beats(64, 200, "w1");
    wfifo_rcount = 11'd0;
    check_seq(28'h0000000, 64, "w1_addr_seq");
    check_eq("w1_last_addr", 64'(beats[63].addr), 64'h1F8);
    wait_idle("w1");

    // Backpressure: five stalled cycles in the middle of the burst
    beats.delete();
    wfifo_rcount = 11'd64;
    wait_beats(10, 50, "bp_pre");
    check_eq("bp_addr_before", 64'(mig.app_addr), 64'h250);
    mig.app_wdf_rdy = 1'b0;
    repeat (5) tick();
    check_eq("bp_addr_frozen",  64'(mig.app_addr), 64'h250);
    check_eq("bp_count_frozen", 64'(beats.size()), 64'd10);
    check_eq("bp_wren_held",    64'(mig.app_wdf_wren), 64'd1);
    mig.app_wdf_rdy = 1'b1;
    wait_beats(64, 200, "bp");
    wfifo_rcount = 11'd0;
    repeat (4) tick();
    check_eq("bp_total_beats", 64'(beats.size()), 64'd64);
    check_seq(28'h0000200, 64, "bp_addr_seq");

    // Ping-pong: the second burst wrapped the 0..1024 window
    check_eq("pp_wr_bank", 64'(wr_bank), 64'd1);
    check_eq("pp_rd_bank", 64'(rd_bank), 64'd0);
    beats.delete();
    wr_burst_len = 8'd4;
    wfifo_rcount = 11'd64;
    wait_beats(4, 50, "pp");
    wfifo_rcount = 11'd0;
    check_eq("pp_next_addr", 64'(beats[0].addr), 64'h0200000);
    check_eq("pp_last_addr", 64'(beats[3].addr), 64'h0200018);
    wait_idle("pp");

    // Arbitration with both streams requesting continuously (last grant was a write)
    exp_cmd  = RD_PRIO ? '{3'd1, 3'd1, 3'd1, 3'd1} : '{3'd1, 3'd0, 3'd1, 3'd0};
    exp_addr = RD_PRIO ? '{28'h100, 28'h120, 28'h140, 28'h160}
                       : '{28'h100, 28'h200020, 28'h120, 28'h200040};
    grants.delete();
    wfifo_rcount = 11'd64;
    rd_enable = 1'b1;
    begin
      int k = 0;
      while (grants.size() < 4 && k < 200) begin
        tick();
        k++;
      end
    end
    wfifo_rcount = 11'd0;
    rd_enable = 1'b0;
    check_eq("arb_grant_count", 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      check_eq($sformatf("arb_cmd_%0d", i),  64'(grants[i].cmd),  64'(exp_cmd[i]));
      check_eq($sformatf("arb_addr_%0d", i), 64'(grants[i].addr), 64'(exp_addr[i]));
    end
    wait_idle("arb");

    // rd_load during a read burst: burst runs full length, next read restarts at rd_addr_min
    exp_base = RD_PRIO ? 28'h180 : 28'h140;
    beats.delete();
    grants.delete();
    rd_burst_len = 8'd16;
    rd_enable = 1'b1;
    wait_beats(3, 50, "ld_pre");
    rd_load = 1'b1;
    repeat (2) tick();
    rd_load = 1'b0;
    wait_beats(17, 100, "ld");
    rd_enable = 1'b0;
    check_eq("ld_first_addr", 64'(beats[0].addr), 64'(exp_base));
    check_seq(exp_base, 16, "ld_full_burst");
    check_eq("ld_restart_addr", 64'(beats[16].addr), 64'h100);
    wait_idle("ld");
    check_eq("ld_grants", 64'(grants.size()), 64'd2);

    // Calibration loss mid-write, then resume from the held address
    exp_base = RD_PRIO ? 28'h0200020 : 28'h0200060;
    beats.delete();
    grants.delete();
    wr_burst_len = 8'd8;
    wfifo_rcount = 11'd64;
    wait_beats(3, 50, "cal_pre");
    held_addr = mig.app_addr;
    mig.app_wdf_rdy = 1'b0;
    mig.init_calib_complete = 1'b0;
    tick();
    check_eq("cal_drop_en",   64'(mig.app_en), 64'd0);
    check_eq("cal_drop_wren", 64'(mig.app_wdf_wren), 64'd0);
    repeat (4) tick();
    check_eq("cal_wait_en", 64'(mig.app_en), 64'd0);
    mig.init_calib_complete = 1'b1;
    mig.app_wdf_rdy = 1'b1;
    wait_beats(11, 100, "cal");
    wfifo_rcount = 11'd0;
    check_eq("cal_held_addr",   64'(held_addr), 64'(exp_base + 28'd24));
    check_eq("cal_resume_addr", 64'(beats[3].addr), 64'(exp_base + 28'd24));
    check_eq("cal_resume_last", 64'(beats[10].addr), 64'(exp_base + 28'd80));
    wait_idle("cal");
    check_eq("cal_grants", 64'(grants.size()), 64'd2);

    // Asynchronous reset in the middle of a burst
    beats.delete();
    wfifo_rcount = 11'd64;
    wait_beats(2, 50, "ar_pre");
    rst_n = 1'b0;
    #1;
    check_eq("ar_app_en",   64'(mig.app_en), 64'd0);
    check_eq("ar_app_cmd",  64'(mig.app_cmd), 64'd1);
    check_eq("ar_app_addr", 64'(mig.app_addr), 64'd0);
    check_eq("ar_wr_bank",  64'(wr_bank), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
